zavala_nonce_engine: RTL

Parametrised nonce-search controller for the zavala miner. Exposes a 32-bit register bank on the miner's read/write/op_address bus and sweeps a programmed nonce range across `NUM_CORES` external hash cores in lock-step batches. It compares each core's top hash word against a target, latches the first winning nonce, and reports results through status, an interrupt and a hashrate counter derived from `MINER_FREQ`.

---
 rtl/zavala_nonce_engine.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/zavala_nonce_engine.sv
// zavala_nonce_engine: register-mapped nonce-range sweeper for NUM_CORES
// external hash cores, run in lock-step batches. It latches the lowest winning
// nonce and measures the dispatch rate over a MINER_FREQ-cycle window.
module zavala_nonce_engine #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned MINER_FREQ = 10000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read,
  input  logic                      write,
  input  logic [4:0]                op_address,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [32*NUM_CORES-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0]      core_done,
  input  logic [32*NUM_CORES-1:0]   core_hash_hi
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_WAIT     = 2'd2;
  localparam logic [1:0] S_EVAL     = 2'd3;

  logic [1:0]           state;
  logic [31:0]          nonce_start, nonce_end, target;
  logic [31:0]          found_nonce, base, hashrate;
  logic [31:0]          win_cnt, acc;
  logic                 irq_en, busy, found, exhausted, aborted;
  logic [NUM_CORES-1:0] pend_mask, hit;

  logic                 ctrl_wr, start_req, abort_req, last_batch, any_hit;
  logic [NUM_CORES-1:0] disp_mask;
  logic [31:0]          disp_add, hit_idx;

  assign ctrl_wr   = write && (op_address == 5'd0);
  // abort takes priority over a start carried in the same write
  assign abort_req = ctrl_wr && writedata[1];
  assign start_req = ctrl_wr && writedata[0] && !writedata[1];
  assign irq       = irq_en && (found || exhausted);
  assign any_hit   = (hit != '0);
  assign last_batch = ({1'b0, base} + 33'(NUM_CORES)) > {1'b0, nonce_end};

  // Batch set, its population count and the lowest hitting core index
  always_comb begin
    disp_mask = '0;
    disp_add  = '0;
    hit_idx   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      disp_mask[i] = ({1'b0, base} + 33'(i)) <= {1'b0, nonce_end};
    end
    if (state == S_DISPATCH && !abort_req) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        disp_add = disp_add + 32'(disp_mask[i]);
      end
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (hit[NUM_CORES-1-i]) hit_idx = 32'(NUM_CORES - 1 - i);
    end
  end

  // Programmable registers; the range/target are frozen while a search runs
  always_ff @(posedge clk) begin
    if (rst) begin
      nonce_start <= '0;
      nonce_end   <= '1;
      target      <= '0;
      irq_en      <= 1'b0;
    end else if (write) begin
      if (op_address == 5'd0) irq_en <= writedata[2];
      if (!busy) begin
        if (op_address == 5'd2) nonce_start <= writedata;
        if (op_address == 5'd3) nonce_end   <= writedata;
        if (op_address == 5'd4) target      <= writedata;
      end
    end
  end

  // Search FSM: dispatch a batch, collect core results, evaluate, repeat
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      base        <= '0;
      found_nonce <= '0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      aborted     <= 1'b0;
      pend_mask   <= '0;
      hit         <= '0;
      core_start  <= '0;
      core_nonce  <= '0;
    end else begin
      core_start <= '0;
      case (state)
        S_IDLE: begin
          if (start_req) begin
            state     <= S_DISPATCH;
            base      <= nonce_start;
            found     <= 1'b0;
            exhausted <= 1'b0;
            aborted   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_DISPATCH: begin
          core_start <= disp_mask;
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (disp_mask[i]) core_nonce[32*i +: 32] <= base + 32'(i);
          end
          pend_mask <= disp_mask;
          hit       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          pend_mask <= pend_mask & ~core_done;
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (core_done[i] && pend_mask[i]) hit[i] <= (core_hash_hi[32*i +: 32] <= target);
          end
          if ((pend_mask & ~core_done) == '0) state <= S_EVAL;
        end
        default: begin
          if (any_hit) begin
            found_nonce <= base + hit_idx;
            found       <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else if (last_batch) begin
            exhausted <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            base  <= base + 32'(NUM_CORES);
            state <= S_DISPATCH;
          end
        end
      endcase
      // abort overrides whatever the state above decided, including a dispatch
      if (abort_req && state != S_IDLE) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        aborted    <= 1'b1;
        pend_mask  <= '0;
        core_start <= '0;
      end
    end
  end

  // Hashrate window: publish the nonce count at each wrap and restart
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt  <= '0;
      acc      <= '0;
      hashrate <= '0;
    end else if (win_cnt == 32'(MINER_FREQ - 1)) begin
      win_cnt  <= '0;
      hashrate <= acc + disp_add;
      acc      <= '0;
    end else begin
      win_cnt <= win_cnt + 32'd1;
      acc     <= acc + disp_add;
    end
  end

  // Registered read port; holds its value between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata <= '0;
    end else if (read) begin
      case (op_address)
        5'd0:    readdata <= {31'b0, irq_en};
        5'd1:    readdata <= {28'b0, aborted, exhausted, found, busy};
        5'd2:    readdata <= nonce_start;
        5'd3:    readdata <= nonce_end;
        5'd4:    readdata <= target;
        5'd5:    readdata <= found_nonce;
        5'd6:    readdata <= base;
        5'd7:    readdata <= hashrate;
        5'd8:    readdata <= 32'(NUM_CORES);
        default: readdata <= '0;
      endcase
    end
  end

endmodule
